// File: rtl/timer_pkg.sv
// Shared state encoding for the countdown timer controller.
package timer_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_EXPIRE = 2'b11
  } state_t;
endpackage

// File: rtl/timer_down_cnt.sv
// Loadable down counter; load takes priority over decrement.
module timer_down_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign count  = count_reg;
  assign is_one = (count_reg == CNT_W'(1));
endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: preset selection, run/pause FSM, expiry alarm
// or periodic auto-reload, driving an embedded down counter.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int NUM_PRESETS = 2,
  parameter bit AUTO_RELOAD = 1'b0,
  localparam int SEL_W      = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         start_stop,
  input  logic                         tick,
  input  logic [NUM_PRESETS*CNT_W-1:0] preset_val,
  output logic [1:0]                   state,
  output logic [SEL_W-1:0]             preset_sel,
  output logic [CNT_W-1:0]             count,
  output logic                         running,
  output logic                         done,
  output logic                         alarm
);
  state_t           state_reg, state_next;
  logic [SEL_W-1:0] preset_sel_reg, preset_sel_next;
  logic             done_reg, done_next;
  logic             running_reg, alarm_reg;

  logic [CNT_W-1:0] presets [NUM_PRESETS];
  logic [CNT_W-1:0] cur_preset;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_load_val;

  for (genvar gi = 0; gi < NUM_PRESETS; gi++) begin : g_preset
    assign presets[gi] = preset_val[gi*CNT_W +: CNT_W];
  end
  assign cur_preset = presets[preset_sel_reg];

  // Simultaneous presses are discarded as ambiguous.
  logic btn_mode, btn_ss;
  assign btn_mode = mode & ~start_stop;
  assign btn_ss   = start_stop & ~mode;

  always_comb begin
    state_next      = state_reg;
    preset_sel_next = preset_sel_reg;
    cnt_load        = 1'b0;
    cnt_load_val    = cur_preset;
    cnt_dec         = 1'b0;
    done_next       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_load = 1'b1;
        if (btn_mode) begin
          preset_sel_next = (preset_sel_reg == SEL_W'(NUM_PRESETS-1)) ? '0
                                                                     : preset_sel_reg + SEL_W'(1);
        end else if (btn_ss && cur_preset != '0) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // A pause press beats a coincident tick.
        if (btn_ss) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          if (cnt_is_one) begin
            done_next = 1'b1;
            cnt_load  = 1'b1;
            if (!AUTO_RELOAD) begin
              cnt_load_val = '0;
              state_next   = ST_EXPIRE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (btn_ss) begin
          state_next = ST_RUN;
        end else if (btn_mode) begin
          state_next = ST_IDLE;
          cnt_load   = 1'b1;
        end
      end
      ST_EXPIRE: begin
        if (btn_mode || btn_ss) begin
          state_next = ST_IDLE;
          cnt_load   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      preset_sel_reg <= '0;
      done_reg       <= 1'b0;
      running_reg    <= 1'b0;
      alarm_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      preset_sel_reg <= preset_sel_next;
      done_reg       <= done_next;
      running_reg    <= (state_next == ST_RUN);
      alarm_reg      <= (state_next == ST_EXPIRE);
    end
  end

  timer_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (count),
    .is_one   (cnt_is_one)
  );

  assign state      = state_reg;
  assign preset_sel = preset_sel_reg;
  assign done       = done_reg;
  assign running    = running_reg;
  assign alarm      = alarm_reg;
endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Parametrised countdown-timer controller: a four-state FSM with an integrated down counter.
- Selects one of NUM_PRESETS preset durations, counts down on an external tick enable, and supports pause/resume.
- On expiry it either raises a held alarm or auto-reloads for periodic operation.
- Sits between the debounced button pulses / 1 Hz tick generator and the display/alarm logic.

Parameters:
- CNT_W, 16: width of count and of each preset value.
- NUM_PRESETS, 2: number of selectable presets (>=1).
- AUTO_RELOAD, 0: 1 = reload the preset and keep running on expiry; 0 = enter EXPIRE.
- SEL_W (localparam), max(1, clog2(NUM_PRESETS)): width of the preset index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  single-cycle pulse: cycle preset / return to idle / acknowledge alarm.
- start_stop  in  1  single-cycle pulse: start, pause or resume.
- tick  in  1  single-cycle count enable (e.g. 1 Hz).
- preset_val  in  NUM_PRESETS*CNT_W  preset i at bits [i*CNT_W +: CNT_W].
- state  out  2  IDLE=00, RUN=01, PAUSE=10, EXPIRE=11.
- preset_sel  out  SEL_W  currently selected preset index.
- count  out  CNT_W  remaining count.
- running  out  1  high iff state==RUN.
- done  out  1  one-cycle pulse on each expiry.
- alarm  out  1  high iff state==EXPIRE.

Behaviour:
- Reset, async on rst high: state=IDLE, preset_sel=0, count=0, done=0, alarm=0, running=0. All outputs are registered.
- Button arbitration: a cycle with mode and start_stop both high is ignored in every state. Only the state's own transitions below apply.
- IDLE:
  - count <= preset[preset_sel] every cycle, so count follows the selection with 1-cycle latency.
  - mode: preset_sel <= preset_sel+1, wrapping from NUM_PRESETS-1 to 0. count reflects the new preset 2 cycles after the press.
  - start_stop: go to RUN only if preset[preset_sel] != 0. A zero preset causes no transition.
  - tick is ignored.
- RUN:
  - tick with count>1: count <= count-1.
  - tick with count==1:
    - done pulses the next cycle.
    - AUTO_RELOAD=0: count <= 0, go to EXPIRE.
    - AUTO_RELOAD=1: count <= preset[preset_sel], stay in RUN.
  - start_stop: go to PAUSE, count held. If tick falls in the same cycle, the press wins and there is no decrement.
  - mode: ignored.
- PAUSE:
  - count held; tick ignored.
  - start_stop: go to RUN. The first decrement happens on the next tick, not in the resume cycle.
  - mode: go to IDLE and reload count from the preset.
- EXPIRE:
  - alarm=1; count holds 0.
  - mode or start_stop (not both): go to IDLE and reload count.
- Preset values changing during RUN/PAUSE have no effect until the next load.
- done never asserts outside an expiry event. Back-to-back auto-reload expiries are allowed (preset=1: done on every tick).
- A count decremented from 1 never underflows. count==0 in RUN is unreachable.
- No other transitions exist. Unused encodings are unreachable; the default case returns to IDLE.

Decomposition:
- Package timer_pkg: state encoding localparams (ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRE) and the state width.
- One sub-module, timer_down_cnt (CNT_W):
  - Ports: clk, rst, load, load_val, dec.
  - Outputs: count, is_one.
  - load has priority over dec.
- FSM, preset mux and button arbitration stay in countdown_timer_ctrl.

Test Plan:
All cases use CNT_W=8, NUM_PRESETS=3, presets {5,3,0}, AUTO_RELOAD=0 unless noted.
- Reset mid-RUN (count=3), then release → state=00, preset_sel=0, count=0, then count=5 one cycle later; done/alarm stay 0.
- mode ×3 in IDLE → preset_sel 1,2,0 and count 3,0,5. start_stop with sel=2 (preset 0) → state stays IDLE.
- sel=1, start_stop, 3 ticks → count 2,1,0. done is a single pulse and state=EXPIRE with alarm=1. Then mode → IDLE, count=3.
- RUN, count=4: start_stop and tick in the same cycle → PAUSE, count=4. Tick in PAUSE → 4. start_stop → RUN. Next tick → 3. mode and start_stop together → no change.
- AUTO_RELOAD=1, preset 3: 7 ticks → count 2,1,3,2,1,3,2. done pulses after ticks 3 and 6; state stays RUN.
- From PAUSE, mode → IDLE with count reloaded to preset. In EXPIRE, start_stop alone → IDLE.
